math_unit_seq: RTL and testbench

Parametrised, registered successor to the 8-bit ripple add/sub datapath with overflow flag. Adds a start/busy/done handshake, registered result and flags, carry-chained ADC/SBB, and a multi-cycle unsigned shift-add multiply. Sits behind the C0 ALU decode: the core issues one operation, then waits for done.

---
 rtl/math_pkg.sv | 39 +++
 rtl/math_unit_seq_add_core.sv | 29 ++
 rtl/math_unit_seq.sv | 175 +++++++++++++++++
 tb/tb_math_unit_seq.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/math_pkg.sv
// Shared definitions for the sequential math unit: opcodes, FSM states,
// flag bit positions and small decode/pack helpers.
package math_pkg;

  localparam logic [2:0] OP_ADD = 3'd0;
  localparam logic [2:0] OP_ADC = 3'd1;
  localparam logic [2:0] OP_SUB = 3'd2;
  localparam logic [2:0] OP_SBB = 3'd3;
  localparam logic [2:0] OP_MUL = 3'd4;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_MUL_RUN = 2'd1,
    ST_DONE    = 2'd2
  } state_t;

  localparam int FLAG_C = 0;
  localparam int FLAG_V = 1;
  localparam int FLAG_Z = 2;
  localparam int FLAG_N = 3;

  // Add-class ops complete in a single cycle through the ripple adder.
  function automatic logic is_add_op(input logic [2:0] op);
    return (op == OP_ADD) || (op == OP_ADC) || (op == OP_SUB) || (op == OP_SBB);
  endfunction

  // Pack the four status bits into their fixed positions.
  function automatic logic [3:0] pack_flags(input logic c, input logic v,
                                            input logic z, input logic n);
    logic [3:0] f;
    f         = 4'b0000;
    f[FLAG_C] = c;
    f[FLAG_V] = v;
    f[FLAG_Z] = z;
    f[FLAG_N] = n;
    return f;
  endfunction

endpackage

// File: rtl/math_unit_seq_add_core.sv
// Ripple-carry adder with carry in, carry out and the carry into the MSB
// (needed for signed overflow). Shared by add-class ops and the MUL step.
module add_core #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  logic             cin,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             c_msb
);

  logic c;

  // Full-adder chain; the carry is a loop-local variable so the chain stays in one block.
  always_comb begin
    c   = cin;
    sum = '0;
    for (int i = 0; i < WIDTH; i++) begin
      sum[i] = x[i] ^ y[i] ^ c;
      c      = (x[i] & y[i]) | (c & (x[i] ^ y[i]));
    end
    cout  = c;
    // Carry into the MSB recovered from that bit's operands and sum.
    c_msb = x[WIDTH-1] ^ y[WIDTH-1] ^ sum[WIDTH-1];
  end

endmodule

// File: rtl/math_unit_seq.sv
// Registered add/sub/multiply unit with start/busy/done handshake.
// Add-class ops finish in one cycle; MUL is a WIDTH-step shift-add loop
// that reuses the same ripple adder on the upper accumulator half.
module math_unit_seq
  import math_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] result_hi,
  output logic             flag_c,
  output logic             flag_v,
  output logic             flag_z,
  output logic             flag_n
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] mcand;
  logic [WIDTH-1:0] acc_hi;
  logic [WIDTH-1:0] acc_lo;
  logic [3:0]       flags;

  logic [WIDTH-1:0] add_x;
  logic [WIDTH-1:0] add_y;
  logic             add_cin;
  logic [WIDTH-1:0] add_sum;
  logic             add_cout;
  logic             add_c_msb;

  logic [WIDTH-1:0] step_hi;
  logic [WIDTH-1:0] step_lo;

  add_core #(.WIDTH(WIDTH)) u_add_core (
    .x     (add_x),
    .y     (add_y),
    .cin   (add_cin),
    .sum   (add_sum),
    .cout  (add_cout),
    .c_msb (add_c_msb)
  );

  // Steer the shared adder: live operands in IDLE, accumulator step in MUL_RUN.
  always_comb begin
    add_x   = a;
    add_y   = b;
    add_cin = 1'b0;
    case (state)
      ST_IDLE: begin
        case (op)
          OP_ADD: begin
            add_y   = b;
            add_cin = 1'b0;
          end
          OP_ADC: begin
            add_y   = b;
            add_cin = c_in;
          end
          OP_SUB: begin
            add_y   = ~b;
            add_cin = 1'b1;
          end
          OP_SBB: begin
            add_y   = ~b;
            add_cin = c_in;
          end
          default: begin
            add_y   = b;
            add_cin = 1'b0;
          end
        endcase
      end
      ST_MUL_RUN: begin
        add_x   = acc_hi;
        add_y   = acc_lo[0] ? mcand : {WIDTH{1'b0}};
        add_cin = 1'b0;
      end
      default: begin
        add_x   = a;
        add_y   = b;
        add_cin = 1'b0;
      end
    endcase
  end

  // Next accumulator after one shift-add step: {carry, sum, multiplier} >> 1.
  always_comb begin
    step_hi = {add_cout, add_sum[WIDTH-1:1]};
    step_lo = {add_sum[0], acc_lo[WIDTH-1:1]};
  end

  // Control FSM with registered handshake, result and flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      cnt       <= '0;
      mcand     <= '0;
      acc_hi    <= '0;
      acc_lo    <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      result    <= '0;
      result_hi <= '0;
      flags     <= 4'b0000;
    end else begin
      case (state)
        ST_IDLE: begin
          done <= 1'b0;
          busy <= 1'b0;
          if (start && is_add_op(op)) begin
            result    <= add_sum;
            result_hi <= '0;
            flags     <= pack_flags(add_cout, add_c_msb ^ add_cout,
                                    (add_sum == '0), add_sum[WIDTH-1]);
            done      <= 1'b1;
            state     <= ST_DONE;
          end else if (start && (op == OP_MUL)) begin
            mcand  <= a;
            acc_lo <= b;
            acc_hi <= '0;
            cnt    <= CNT_W'(WIDTH);
            busy   <= 1'b1;
            state  <= ST_MUL_RUN;
          end else begin
            state <= ST_IDLE;
          end
        end
        ST_MUL_RUN: begin
          acc_hi <= step_hi;
          acc_lo <= step_lo;
          cnt    <= cnt - CNT_W'(1);
          if (cnt == CNT_W'(1)) begin
            result    <= step_lo;
            result_hi <= step_hi;
            flags     <= pack_flags((step_hi != '0), 1'b0,
                                    ({step_hi, step_lo} == '0), step_hi[WIDTH-1]);
            busy      <= 1'b0;
            done      <= 1'b1;
            state     <= ST_DONE;
          end else begin
            busy  <= 1'b1;
            state <= ST_MUL_RUN;
          end
        end
        ST_DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= ST_IDLE;
        end
        default: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= ST_IDLE;
        end
      endcase
    end
  end

  assign flag_c = flags[FLAG_C];
  assign flag_v = flags[FLAG_V];
  assign flag_z = flags[FLAG_Z];
  assign flag_n = flags[FLAG_N];

endmodule

// File: tb/tb_math_unit_seq.sv
// Directed self-checking bench for math_unit_seq (WIDTH=8).
module tb_math_unit_seq;

  localparam int WIDTH = 8;

  logic             clk;
  logic             rst_n;
  logic             start;
  logic [2:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             c_in;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;
  logic [WIDTH-1:0] result_hi;
  logic             flag_c;
  logic             flag_v;
  logic             flag_z;
  logic             flag_n;

  int n_checks = 0;
  int n_fail   = 0;

  math_unit_seq #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .op        (op),
    .a         (a),
    .b         (b),
    .c_in      (c_in),
    .busy      (busy),
    .done      (done),
    .result    (result),
    .result_hi (result_hi),
    .flag_c    (flag_c),
    .flag_v    (flag_v),
    .flag_z    (flag_z),
    .flag_n    (flag_n)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Flags packed as {C,V,Z,N} for compact comparisons.
  function automatic logic [3:0] cvzn();
    return {flag_c, flag_v, flag_z, flag_n};
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one request for a single edge; returns just after the accept edge.
  task automatic issue(input logic [2:0] o, input logic [7:0] av, input logic [7:0] bv, input logic ci);
    op = o; a = av; b = bv; c_in = ci; start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // Count edges until done is seen, bounded.
  task automatic wait_done(output int n);
    n = -1;
    for (int k = 1; k <= 30; k++) begin
      tick();
      if (done) begin
        n = k;
        break;
      end
    end
  endtask

  int lat;
  int ndone;

  initial begin
    rst_n = 1'b0; start = 1'b0; op = 3'd0; a = 8'h00; b = 8'h00; c_in = 1'b0;
    tick(); tick();
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_result", {result_hi, result}, 16'h0000);
    check("rst_flags", cvzn(), 4'b0000);
    rst_n = 1'b1;
    tick();

    // ADD 7F+01: signed overflow into negative
    issue(3'd0, 8'h7F, 8'h01, 1'b0);
    check("add_done", done, 1'b1);
    check("add_result", result, 8'h80);
    check("add_cvzn", cvzn(), 4'b0101);
    tick();
    check("add_done_pulse", done, 1'b0);

    // MUL FF*FF = FE01, busy 8 cycles then done
    issue(3'd4, 8'hFF, 8'hFF, 1'b0);
    check("mul_busy0", {busy, done}, 2'b10);
    for (int k = 1; k <= 8; k++) begin
      tick();
      if (k < 8) check("mul_busy_run", {busy, done}, 2'b10);
      else       check("mul_done9", {busy, done}, 2'b01);
    end
    check("mul_ff_hi", result_hi, 8'hFE);
    check("mul_ff_lo", result, 8'h01);
    check("mul_ff_cvzn", cvzn(), 4'b1001);
    tick();

    // ADC FF+00+1: wraps to zero, result_hi cleared from previous MUL
    issue(3'd1, 8'hFF, 8'h00, 1'b1);
    check("adc_result", result, 8'h00);
    check("adc_hi", result_hi, 8'h00);
    check("adc_cvzn", cvzn(), 4'b1010);
    tick();

    // SUB 05-07: borrow
    issue(3'd2, 8'h05, 8'h07, 1'b0);
    check("sub1_result", result, 8'hFE);
    check("sub1_cvzn", cvzn(), 4'b0001);
    tick();

    // SUB 80-01: signed overflow, no borrow
    issue(3'd2, 8'h80, 8'h01, 1'b0);
    check("sub2_result", result, 8'h7F);
    check("sub2_cvzn", cvzn(), 4'b1100);
    tick();

    // SBB 10-01 with borrow pending (c_in=0): 0x10-0x01-1 = 0x0E
    issue(3'd3, 8'h10, 8'h01, 1'b0);
    check("sbb_result", result, 8'h0E);
    check("sbb_cvzn", cvzn(), 4'b1000);
    tick();

    // Reserved opcode: nothing happens, outputs hold
    issue(3'd5, 8'h33, 8'h44, 1'b0);
    check("rsv_done_busy", {busy, done}, 2'b00);
    tick();
    check("rsv_hold", {done, result}, {1'b0, 8'h0E});

    // MUL 00*37 = 0
    issue(3'd4, 8'h00, 8'h37, 1'b0);
    wait_done(lat);
    check("mul0_latency", lat, 8);
    check("mul0_result", {result_hi, result}, 16'h0000);
    check("mul0_cvzn", cvzn(), 4'b0010);
    tick();

    // MUL 12*34 = 03A8 with ADD 1+1 start held through the run and the DONE cycle
    issue(3'd4, 8'h12, 8'h34, 1'b0);
    op = 3'd0; a = 8'h01; b = 8'h01; start = 1'b1;
    ndone = 0;
    lat = -1;
    for (int k = 1; k <= 20; k++) begin
      tick();
      if (done) begin
        ndone++;
        lat = k;
        break;
      end
    end
    check("ign_latency", lat, 8);
    check("ign_result", {result_hi, result}, 16'h03A8);
    tick();
    start = 1'b0;
    check("ign_done_cycle_start", {busy, done, result}, {2'b00, 8'hA8});
    tick();
    if (done) ndone++;
    check("ign_one_done", ndone, 1);
    check("ign_hold", {result_hi, result}, 16'h03A8);

    // Reset in the middle of a MUL
    issue(3'd4, 8'hFF, 8'hFF, 1'b0);
    tick(); tick(); tick();
    rst_n = 1'b0;
    #1;
    check("mrst_busy_done", {busy, done}, 2'b00);
    check("mrst_result", {result_hi, result}, 16'h0000);
    check("mrst_flags", cvzn(), 4'b0000);
    tick(); tick();
    rst_n = 1'b1;
    ndone = 0;
    for (int k = 0; k < 12; k++) begin
      tick();
      if (done || busy) ndone++;
    end
    check("mrst_no_done", ndone, 0);

    // ADD after reset completes normally
    issue(3'd0, 8'h01, 8'h01, 1'b0);
    check("post_rst_add", {done, result}, {1'b1, 8'h02});
    check("post_rst_cvzn", cvzn(), 4'b0000);
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
